flog_exp2_bf16: RTL and testbench

Iterative bfloat16 base-2 antilog unit, the inverse of the FLOG log2 datapath: computes 2^x for one bfloat16 operand per transaction. It sits downstream of the log2 pipeline, so log-domain results can be converted back to linear bfloat16 (log2 → arithmetic → exp2). It uses a valid/ready handshake on both sides and one shift-and-multiply iteration per fraction bit.

---
 rtl/flog_exp2_bf16_if.sv | 24 ++
 rtl/flog_exp2_bf16.sv | 192 +++++++++++++++++++
 tb/tb_flog_exp2_bf16.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/flog_exp2_bf16_if.sv
// Operand/result handshake bundle for the bfloat16 exp2 unit.
// master: producer of operands and consumer of results; slave: the unit.
interface flog_exp2_bf16_if;
  logic       sign;
  logic [7:0] exponent;
  logic [6:0] fractional;
  logic       valid_i;
  logic       ready_o;
  logic       s_res_o;
  logic [7:0] e_res_o;
  logic [6:0] f_res_o;
  logic       valid_o;
  logic       ready_i;

  modport master (
    output sign, exponent, fractional, valid_i, ready_i,
    input  ready_o, s_res_o, e_res_o, f_res_o, valid_o
  );

  modport slave (
    input  sign, exponent, fractional, valid_i, ready_i,
    output ready_o, s_res_o, e_res_o, f_res_o, valid_o
  );
endinterface

// File: rtl/flog_exp2_bf16.sv
// Iterative bfloat16 2^x. The operand is split into an integer part, which
// becomes the result exponent, and a fraction F whose bits each multiply a
// 1.(ACC_W-1) accumulator by 2^(2^-k), one bit per ITER cycle, MSB first.
// The final rounding is applied to the last ITER product on the same edge,
// so a normal operand produces valid_o FRAC_W+2 edges after acceptance
// (accept edge included) and a special operand after 2.
module flog_exp2_bf16 #(
  parameter int FRAC_W = 12,
  parameter int ACC_W  = 16
) (
  input  logic            clk,
  input  logic            rst,
  flog_exp2_bf16_if.slave bus
);
  localparam int XW = FRAC_W + 9;
  localparam int CW = $clog2(FRAC_W + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_ITER = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // round(2^(2^-k) * 2^(ACC_W-1)) for ACC_W = 16
  function automatic logic [ACC_W-1:0] c_const(input int k);
    case (k)
      1:       c_const = 16'hB505;
      2:       c_const = 16'h9838;
      3:       c_const = 16'h8B96;
      4:       c_const = 16'h85AB;
      5:       c_const = 16'h82CE;
      6:       c_const = 16'h8165;
      7:       c_const = 16'h80B2;
      8:       c_const = 16'h8059;
      9:       c_const = 16'h802C;
      10:      c_const = 16'h8016;
      11:      c_const = 16'h800B;
      12:      c_const = 16'h8006;
      default: c_const = 16'h8000;
    endcase
  endfunction

  logic [1:0]        state;
  logic              sgn_r;
  logic [7:0]        exp_r;
  logic [6:0]        frc_r;
  logic [ACC_W-1:0]  acc;
  logic [FRAC_W-1:0] fbits;
  logic [CW-1:0]     cnt;
  logic signed [9:0] e_r;
  logic              s_res;
  logic [7:0]        e_res;
  logic [6:0]        f_res;
  logic              vld;

  // conversion of the captured operand to fixed point
  logic signed [9:0]     ue, sh;
  logic [9:0]            rsh;
  logic [XW-1:0]         mag, mag_fix;
  logic signed [XW-1:0]  x_fix, int_part;
  logic signed [9:0]     e_pre;
  logic                  sp_hit;
  logic [7:0]            sp_e;
  logic [6:0]            sp_f;

  // align {1,frac} to Q8.FRAC_W, negate, split into floor and fraction,
  // and classify operands that never reach the iteration
  always_comb begin
    ue      = $signed({2'b00, exp_r}) - 10'sd127;
    sh      = ue + $signed(10'(FRAC_W - 7));
    rsh     = 10'(-sh);
    mag     = XW'({1'b1, frc_r});
    mag_fix = '0;
    if (!sh[9])          mag_fix = mag << sh;
    else if (rsh < 10'd8) mag_fix = mag >> rsh;
    x_fix    = sgn_r ? -$signed(mag_fix) : $signed(mag_fix);
    int_part = x_fix >>> FRAC_W;
    e_pre    = $signed(int_part[9:0] + 10'd127);

    sp_hit = 1'b1;
    sp_e   = 8'd0;
    sp_f   = 7'd0;
    if (exp_r == 8'hFF && frc_r != 7'd0) begin
      sp_e = 8'hFF;
      sp_f = 7'h40;
    end else if (exp_r == 8'hFF) begin
      sp_e = sgn_r ? 8'd0 : 8'hFF;
    end else if (exp_r == 8'd0) begin
      sp_e = 8'd127;
    end else if (ue >= 10'sd7) begin
      sp_e = sgn_r ? 8'd0 : 8'hFF;
    end else if (e_pre <= 10'sd0) begin
      sp_e = 8'd0;
    end else if (e_pre >= 10'sd255) begin
      sp_e = 8'hFF;
    end else begin
      sp_hit = 1'b0;
    end
  end

  // one shift-and-multiply step plus the rounding used on the last step
  logic [2*ACC_W-1:0] prod;
  logic [ACC_W-1:0]   acc_nx;
  logic [7:0]         mant_sum;
  logic signed [9:0]  e_fin;

  // acc stays in [1,2): product of two 1.x values truncated back to 1.x
  always_comb begin
    prod     = {{ACC_W{1'b0}}, acc} * {{ACC_W{1'b0}}, c_const(int'(cnt) + 1)};
    acc_nx   = fbits[FRAC_W-1] ? prod[2*ACC_W-2:ACC_W-1] : acc;
    mant_sum = {1'b0, acc_nx[ACC_W-2:ACC_W-8]} + {7'd0, acc_nx[ACC_W-9]};
    e_fin    = mant_sum[7] ? e_r + 10'sd1 : e_r;
  end

  // bits deliberately dropped by truncation and range reduction
  logic unused_bits;
  assign unused_bits = ^{prod[2*ACC_W-1], prod[ACC_W-2:0],
                         acc_nx[ACC_W-10:0], int_part[XW-1:10]};

  // control FSM and registered result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      sgn_r <= 1'b0;
      exp_r <= 8'd0;
      frc_r <= 7'd0;
      acc   <= '0;
      fbits <= '0;
      cnt   <= '0;
      e_r   <= '0;
      s_res <= 1'b0;
      e_res <= 8'd0;
      f_res <= 7'd0;
      vld   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.valid_i) begin
            sgn_r <= bus.sign;
            exp_r <= bus.exponent;
            frc_r <= bus.fractional;
            state <= S_CONV;
          end
        end
        S_CONV: begin
          if (sp_hit) begin
            s_res <= 1'b0;
            e_res <= sp_e;
            f_res <= sp_f;
            vld   <= 1'b1;
            state <= S_DONE;
          end else begin
            acc   <= {1'b1, {(ACC_W-1){1'b0}}};
            fbits <= x_fix[FRAC_W-1:0];
            cnt   <= '0;
            e_r   <= e_pre;
            state <= S_ITER;
          end
        end
        S_ITER: begin
          acc   <= acc_nx;
          fbits <= fbits << 1;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(FRAC_W - 1)) begin
            s_res <= 1'b0;
            if (e_fin >= 10'sd255) begin
              e_res <= 8'hFF;
              f_res <= 7'd0;
            end else begin
              e_res <= e_fin[7:0];
              f_res <= mant_sum[7] ? 7'd0 : mant_sum[6:0];
            end
            vld   <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.ready_i) begin
            vld   <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.ready_o = (state == S_IDLE);
  assign bus.valid_o = vld;
  assign bus.s_res_o = s_res;
  assign bus.e_res_o = e_res;
  assign bus.f_res_o = f_res;
endmodule

// File: tb/tb_flog_exp2_bf16.sv
// Directed bench for flog_exp2_bf16: vector table plus backpressure and
// mid-operation reset sequences.
module tb_flog_exp2_bf16;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  flog_exp2_bf16_if bus();
  flog_exp2_bf16 dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    string      name;
    logic       s;
    logic [7:0] e;
    logic [6:0] f;
    logic       xs;
    logic [7:0] xe;
    logic [6:0] xf;
    int         lat;
  } vec_t;

  localparam int NV = 16;
  localparam int LN = 14;
  localparam int LS = 2;

  vec_t vecs[NV];
  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] res();
    return {bus.s_res_o, bus.e_res_o, bus.f_res_o};
  endfunction

  // one transaction with ready_i high: latency, result, handshake release
  task automatic run_vec(input vec_t v);
    int lat;
    check({v.name, " ready"}, 32'(bus.ready_o), 32'd1);
    bus.sign       = v.s;
    bus.exponent   = v.e;
    bus.fractional = v.f;
    bus.valid_i    = 1'b1;
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    lat = 1;
    while (!bus.valid_o && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({v.name, " latency"}, 32'(lat), 32'(v.lat));
    check({v.name, " result"}, 32'(res()), 32'({v.xs, v.xe, v.xf}));
    @(posedge clk); #1;
    check({v.name, " release"}, 32'({bus.valid_o, bus.ready_o}), 32'b01);
  endtask

  initial begin
    int lat;
    int seen;
    logic [15:0] held;

    vecs[0]  = '{"one",      1'b0, 8'd127, 7'h00, 1'b0, 8'd128, 7'h00, LN};
    vecs[1]  = '{"neg_one",  1'b1, 8'd127, 7'h00, 1'b0, 8'd126, 7'h00, LN};
    vecs[2]  = '{"three",    1'b0, 8'd128, 7'h40, 1'b0, 8'd130, 7'h00, LN};
    vecs[3]  = '{"half",     1'b0, 8'd126, 7'h00, 1'b0, 8'd127, 7'h35, LN};
    vecs[4]  = '{"three_q",  1'b0, 8'd126, 7'h40, 1'b0, 8'd127, 7'h57, LN};
    vecs[5]  = '{"neg_half", 1'b1, 8'd126, 7'h00, 1'b0, 8'd126, 7'h35, LN};
    vecs[6]  = '{"nan",      1'b0, 8'd255, 7'h41, 1'b0, 8'd255, 7'h40, LS};
    vecs[7]  = '{"neg_inf",  1'b1, 8'd255, 7'h00, 1'b0, 8'd0,   7'h00, LS};
    vecs[8]  = '{"pos_inf",  1'b0, 8'd255, 7'h00, 1'b0, 8'd255, 7'h00, LS};
    vecs[9]  = '{"big_pos",  1'b0, 8'd134, 7'h48, 1'b0, 8'd255, 7'h00, LS};
    vecs[10] = '{"big_neg",  1'b1, 8'd134, 7'h48, 1'b0, 8'd0,   7'h00, LS};
    vecs[11] = '{"denorm",   1'b0, 8'd0,   7'h12, 1'b0, 8'd127, 7'h00, LS};
    vecs[12] = '{"m127",     1'b1, 8'd133, 7'h7E, 1'b0, 8'd0,   7'h00, LS};
    vecs[13] = '{"p126",     1'b0, 8'd133, 7'h7C, 1'b0, 8'd253, 7'h00, LN};
    vecs[14] = '{"tiny_pos", 1'b0, 8'd100, 7'h00, 1'b0, 8'd127, 7'h00, LN};
    vecs[15] = '{"tiny_neg", 1'b1, 8'd100, 7'h00, 1'b0, 8'd127, 7'h00, LN};

    bus.sign = 1'b0; bus.exponent = 8'd0; bus.fractional = 7'd0;
    bus.valid_i = 1'b0; bus.ready_i = 1'b1;

    #12;
    check("reset ready", 32'(bus.ready_o), 32'd1);
    check("reset valid", 32'(bus.valid_o), 32'd0);
    check("reset result", 32'(res()), 32'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) run_vec(vecs[i]);

    // backpressure: result held, operand offers ignored while in DONE
    bus.ready_i = 1'b0;
    bus.sign = 1'b0; bus.exponent = 8'd126; bus.fractional = 7'h00;
    bus.valid_i = 1'b1;
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    lat = 1;
    while (!bus.valid_o && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp latency", 32'(lat), 32'(LN));
    held = {1'b0, 8'd127, 7'h35};
    bus.sign = 1'b1; bus.exponent = 8'd255; bus.fractional = 7'h00;
    bus.valid_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("bp hold valid", 32'(bus.valid_o), 32'd1);
      check("bp hold ready", 32'(bus.ready_o), 32'd0);
      check("bp hold result", 32'(res()), 32'(held));
    end
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    @(posedge clk); #1;
    check("bp release", 32'({bus.valid_o, bus.ready_o}), 32'b01);
    @(posedge clk); #1;
    check("bp no accept", 32'({bus.valid_o, bus.ready_o, res()}), 32'({2'b01, held}));

    // asynchronous reset in the middle of ITER
    bus.sign = 1'b0; bus.exponent = 8'd127; bus.fractional = 7'h00;
    bus.valid_i = 1'b1;
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("arst result", 32'(res()), 32'd0);
    check("arst valid", 32'(bus.valid_o), 32'd0);
    check("arst ready", 32'(bus.ready_o), 32'd1);
    @(negedge clk) rst = 1'b1;
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.valid_o) seen++;
    end
    check("arst no stale valid", 32'(seen), 32'd0);
    run_vec(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
